// File: rtl/prog_loader.sv
// Byte-stream programming front end: parses HDR/ADDR/CNT/data[/CSUM] frames and issues
// one-cycle instruction-memory writes. Optional trailing checksum: define PROG_LOADER_CSUM_EN.
`ifndef LOG_CORES
`define LOG_CORES 3
`endif
`ifndef PC_WIDTH
`define PC_WIDTH 5
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

module prog_loader #(
    parameter int LOG_CORES   = `LOG_CORES,
    parameter int PC_WIDTH    = `PC_WIDTH,
    parameter int INSTR_WIDTH = `INSTR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   we,
    output logic [LOG_CORES-1:0]   sel,
    output logic [PC_WIDTH-1:0]    waddr,
    output logic [INSTR_WIDTH-1:0] wdata,
    output logic                   busy,
    output logic                   done,
    output logic                   csum_err
);
    localparam int IB  = (INSTR_WIDTH + 7) / 8;
    localparam int BCW = $clog2(IB + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_CNT   = 3'd2,
        ST_DATA  = 3'd3,
        ST_WRITE = 3'd4
`ifdef PROG_LOADER_CSUM_EN
        , ST_CSUM = 3'd5
`endif
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [LOG_CORES-1:0]   sel_r;
    logic [PC_WIDTH-1:0]    waddr_r;
    logic [INSTR_WIDTH-1:0] wdata_r;
    logic                   we_r;
    logic                   done_r;
    logic [8:0]             left_r;
    logic [BCW-1:0]         bcnt_r;
    logic                   accept_s;
    logic                   frame_end_s;

    assign accept_s = in_valid && (state_r != ST_WRITE);

    // Next-state decode and end-of-frame detection
    always_comb begin
        state_nxt_s = state_r;
        frame_end_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && (in_data[7:6] == 2'b10)) begin
                    state_nxt_s = ST_ADDR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (accept_s) begin
                    state_nxt_s = ST_CNT;
                end else begin
                    state_nxt_s = ST_ADDR;
                end
            end
            ST_CNT: begin
                if (accept_s) begin
                    state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_CNT;
                end
            end
            ST_DATA: begin
                if (accept_s && (bcnt_r == BCW'(IB - 1))) begin
                    state_nxt_s = ST_WRITE;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_WRITE: begin
                if (left_r != 9'd1) begin
                    state_nxt_s = ST_DATA;
                end else begin
`ifdef PROG_LOADER_CSUM_EN
                    state_nxt_s = ST_CSUM;
`else
                    state_nxt_s = ST_IDLE;
                    frame_end_s = 1'b1;
`endif
                end
            end
`ifdef PROG_LOADER_CSUM_EN
            ST_CSUM: begin
                if (accept_s) begin
                    state_nxt_s = ST_IDLE;
                    frame_end_s = 1'b1;
                end else begin
                    state_nxt_s = ST_CSUM;
                end
            end
`endif
            default: begin
                state_nxt_s = ST_IDLE;
                frame_end_s = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Registered strobes: we covers exactly the WRITE cycle, done the cycle after frame end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r   <= 1'b0;
            done_r <= 1'b0;
        end else begin
            we_r   <= (state_nxt_s == ST_WRITE);
            done_r <= frame_end_s;
        end
    end

    // Frame field capture, instruction shift register and burst bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_r   <= '0;
            waddr_r <= '0;
            wdata_r <= '0;
            left_r  <= 9'd0;
            bcnt_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && (in_data[7:6] == 2'b10)) begin
                        sel_r <= in_data[LOG_CORES-1:0];
                    end
                end
                ST_ADDR: begin
                    if (accept_s) begin
                        waddr_r <= in_data[PC_WIDTH-1:0];
                    end
                end
                ST_CNT: begin
                    if (accept_s) begin
                        left_r <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                        bcnt_r <= '0;
                    end
                end
                ST_DATA: begin
                    if (accept_s) begin
                        // Truncating cast drops excess high bits of the first byte
                        wdata_r <= INSTR_WIDTH'({wdata_r, in_data});
                        bcnt_r  <= (bcnt_r == BCW'(IB - 1)) ? '0 : bcnt_r + BCW'(1);
                    end
                end
                ST_WRITE: begin
                    waddr_r <= waddr_r + PC_WIDTH'(1);
                    left_r  <= left_r - 9'd1;
                end
                default: begin
                    bcnt_r <= bcnt_r;
                end
            endcase
        end
    end

`ifdef PROG_LOADER_CSUM_EN
    logic [7:0] sum_r;
    logic [7:0] sum_nxt_s;
    logic       csum_err_r;

    assign sum_nxt_s = sum_r + in_data;

    // Running checksum over HDR..last data byte; sticky error on a bad trailer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r      <= 8'd0;
            csum_err_r <= 1'b0;
        end else if (accept_s) begin
            if (state_r == ST_IDLE) begin
                sum_r <= in_data;
            end else if (state_r == ST_CSUM) begin
                if (sum_nxt_s != 8'd0) begin
                    csum_err_r <= 1'b1;
                end
            end else begin
                sum_r <= sum_nxt_s;
            end
        end
    end

    assign csum_err = csum_err_r;
`else
    assign csum_err = 1'b0;
`endif

    assign in_ready = (state_r != ST_WRITE);
    assign busy     = (state_r != ST_IDLE);
    assign we       = we_r;
    assign done     = done_r;
    assign sel      = sel_r;
    assign waddr    = waddr_r;
    assign wdata    = wdata_r;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader (LOG_CORES=3, PC_WIDTH=5, INSTR_WIDTH=32).
`timescale 1ns/1ps
module tb_prog_loader;
    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        we;
    logic [2:0]  sel;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        csum_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0]  q_sel  [$];
    logic [4:0]  q_addr [$];
    logic [31:0] q_data [$];
    int   n_done      = 0;
    int   n_done_after_we = 0;
    int   we_rdy_bad  = 0;
    int   done_busy_bad = 0;
    logic prev_we     = 1'b0;

    prog_loader #(.LOG_CORES(3), .PC_WIDTH(5), .INSTR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .we(we), .sel(sel), .waddr(waddr), .wdata(wdata),
        .busy(busy), .done(done), .csum_err(csum_err)
    );

    always #5 clk = ~clk;

    // Mid-cycle monitor of write strobes and done pulses
    always @(negedge clk) begin
        if (we) begin
            q_sel.push_back(sel);
            q_addr.push_back(waddr);
            q_data.push_back(wdata);
            if (in_ready) we_rdy_bad++;
        end
        if (done) begin
            n_done++;
            if (prev_we) n_done_after_we++;
            if (busy) done_busy_bad++;
        end
        prev_we = we;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int guard;
        guard = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 10) check_eq("ready_timeout", 64'd0, 64'd1);
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        send(w[31:24]); send(w[23:16]); send(w[15:8]); send(w[7:0]);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        q_sel.delete(); q_addr.delete(); q_data.delete();
        n_done = 0; n_done_after_we = 0; we_rdy_bad = 0; done_busy_bad = 0;
    endtask

    task automatic expect_write(input string tag, input logic [2:0] s,
                                input logic [4:0] a, input logic [31:0] d);
        if (q_sel.size() == 0) begin
            check_eq({tag, "_missing"}, 64'd0, 64'd1);
        end else begin
            check_eq({tag, "_sel"},   q_sel.pop_front(),  s);
            check_eq({tag, "_waddr"}, q_addr.pop_front(), a);
            check_eq({tag, "_wdata"}, q_data.pop_front(), d);
        end
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_we", we, 1'b0);
        check_eq("rst_sel", sel, 3'd0);
        check_eq("rst_waddr", waddr, 5'd0);
        check_eq("rst_wdata", wdata, 32'd0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_csum_err", csum_err, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1'b1);

`ifndef PROG_LOADER_CSUM_EN
        // Single write, continuous valid
        clear_mon();
        send(8'h85); send(8'h04); send(8'h01); send_word(32'hDEADBEEF);
        idle(4);
        check_eq("single_nwr", q_sel.size(), 1);
        expect_write("single", 3'd5, 5'd4, 32'hDEADBEEF);
        check_eq("single_ready_low", we_rdy_bad, 0);
        check_eq("single_done", n_done, 1);
        check_eq("single_done_after_we", n_done_after_we, 1);
        check_eq("single_done_busy", done_busy_bad, 0);

        // Burst with address wrap
        clear_mon();
        send(8'h82); send(8'h1E); send(8'h03);
        send_word(32'h11111111); send_word(32'h22222222); send_word(32'h33333333);
        idle(4);
        check_eq("burst_nwr", q_sel.size(), 3);
        expect_write("burst0", 3'd2, 5'd30, 32'h11111111);
        expect_write("burst1", 3'd2, 5'd31, 32'h22222222);
        expect_write("burst2", 3'd2, 5'd0,  32'h33333333);
        check_eq("burst_done", n_done, 1);
        check_eq("burst_wdata_hold", wdata, 32'h33333333);
        check_eq("burst_waddr_after", waddr, 5'd1);

        // Stall mid-instruction
        clear_mon();
        send(8'h85); send(8'h04); send(8'h01); send(8'hDE); send(8'hAD);
        idle(5);
        check_eq("stall_no_we", q_sel.size(), 0);
        check_eq("stall_busy", busy, 1'b1);
        send(8'hBE); send(8'hEF);
        idle(4);
        check_eq("stall_nwr", q_sel.size(), 1);
        expect_write("stall", 3'd5, 5'd4, 32'hDEADBEEF);
        check_eq("stall_done", n_done, 1);

        // Junk headers then a valid frame
        clear_mon();
        send(8'h00); check_eq("junk00_busy", busy, 1'b0);
        send(8'hFF); check_eq("junkff_busy", busy, 1'b0);
        send(8'h41); check_eq("junk41_busy", busy, 1'b0);
        send(8'h87); check_eq("valid_hdr_busy", busy, 1'b1);
        send(8'h10); send(8'h01); send_word(32'h01020304);
        idle(4);
        check_eq("junk_nwr", q_sel.size(), 1);
        expect_write("junk", 3'd7, 5'd16, 32'h01020304);

        // Reset mid-frame, then a full frame
        clear_mon();
        send(8'h83); send(8'h05); send(8'h01); send(8'hAA); send(8'hBB);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("midrst_we", we, 1'b0);
        check_eq("midrst_sel", sel, 3'd0);
        check_eq("midrst_waddr", waddr, 5'd0);
        check_eq("midrst_wdata", wdata, 32'd0);
        check_eq("midrst_busy", busy, 1'b0);
        rst_n = 1'b1;
        idle(3);
        check_eq("midrst_nwr", q_sel.size(), 0);
        send(8'h83); send(8'h05); send(8'h01); send_word(32'hAABBCCDD);
        idle(4);
        check_eq("postrst_nwr", q_sel.size(), 1);
        expect_write("postrst", 3'd3, 5'd5, 32'hAABBCCDD);
        check_eq("csum_err_off", csum_err, 1'b0);
`else
        // Good checksum
        clear_mon();
        send(8'h80); send(8'h00); send(8'h01); send_word(32'h00000001);
        idle(2);
        check_eq("csum_wait_busy", busy, 1'b1);
        check_eq("csum_wait_done", n_done, 0);
        send(8'h7E);
        idle(3);
        check_eq("csum_good_nwr", q_sel.size(), 1);
        expect_write("csum_good", 3'd0, 5'd0, 32'h00000001);
        check_eq("csum_good_done", n_done, 1);
        check_eq("csum_good_err", csum_err, 1'b0);

        // Bad checksum: write stays, error is sticky
        clear_mon();
        send(8'h80); send(8'h00); send(8'h01); send_word(32'h00000001);
        send(8'h00);
        idle(3);
        check_eq("csum_bad_nwr", q_sel.size(), 1);
        expect_write("csum_bad", 3'd0, 5'd0, 32'h00000001);
        check_eq("csum_bad_done", n_done, 1);
        check_eq("csum_bad_err", csum_err, 1'b1);
        send(8'h80); send(8'h00); send(8'h01); send_word(32'h00000001);
        send(8'h7E);
        idle(3);
        check_eq("csum_sticky", csum_err, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
